// File: rtl/gshare_pht_pkg.sv
`default_nettype none
// ============================================================================
// gshare_pht_pkg : shared widths and 2-bit counter encodings for the BPU PHT
// Revision: 1.0
// ============================================================================
package gshare_pht_pkg;

   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_CTR_WIDTH  = 2;
   localparam int DEF_GHR_WIDTH  = 9;
   localparam int DEF_CTR_INIT   = 1;

   // Canonical 2-bit encodings: strongly/weakly not-taken, weakly/strongly taken
   typedef enum logic [1:0] {
      CTR_SNT = 2'd0,
      CTR_WNT = 2'd1,
      CTR_WT  = 2'd2,
      CTR_ST  = 2'd3
   } ctr2_e;

endpackage
`default_nettype wire

// File: rtl/bpu_sat_ctr.sv
`default_nettype none
// ============================================================================
// bpu_sat_ctr : one saturating up/down counter; in_data=1 counts up, 0 down.
// Revision: 1.0
// ============================================================================
module bpu_sat_ctr
   import gshare_pht_pkg::*;
#(
   parameter int CTR_WIDTH = DEF_CTR_WIDTH,
   parameter int INIT      = DEF_CTR_INIT
) (
   input  logic in_Clk,
   input  logic in_Rst,
   input  logic in_En,
   input  logic in_data,
   output logic out_msb
);

   localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

   logic [CTR_WIDTH-1:0] ctr_q;
   logic [CTR_WIDTH-1:0] ctr_d;

   always_comb begin
      ctr_d = ctr_q;
      if (in_En) begin
         if (in_data && (ctr_q != CTR_MAX))
            ctr_d = ctr_q + 1'b1;
         else if (!in_data && (ctr_q != '0))
            ctr_d = ctr_q - 1'b1;
      end
   end

   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst)
         ctr_q <= CTR_WIDTH'(INIT);
      else
         ctr_q <= ctr_d;
   end

   assign out_msb = ctr_q[CTR_WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// ============================================================================
// gshare_pht : gshare pattern history table with speculative GHR, registered
//              prediction port, EX update port and GHR repair on mispredict.
// Revision: 1.0
// ============================================================================
module gshare_pht
   import gshare_pht_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CTR_WIDTH  = DEF_CTR_WIDTH,
   parameter int GHR_WIDTH  = DEF_GHR_WIDTH,
   parameter int CTR_INIT   = DEF_CTR_INIT
) (
   input  logic                  in_Clk,
   input  logic                  in_Rst,
   input  logic                  in_pred_valid,
   input  logic [ADDR_WIDTH-1:0] in_pred_pc,
   output logic                  out_pred_valid,
   output logic                  out_prediction,
   output logic [GHR_WIDTH-1:0]  out_pred_ghr,
   input  logic                  in_upd_valid,
   input  logic [ADDR_WIDTH-1:0] in_upd_pc,
   input  logic [GHR_WIDTH-1:0]  in_upd_ghr,
   input  logic                  in_upd_taken,
   input  logic                  in_upd_mispredict,
   output logic [GHR_WIDTH-1:0]  out_ghr
);

   localparam int NUM_CTR = 2 ** ADDR_WIDTH;

   logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
   logic                  pred_valid_q, pred_valid_d;
   logic                  prediction_q, prediction_d;
   logic [GHR_WIDTH-1:0]  pred_ghr_q, pred_ghr_d;

   logic [ADDR_WIDTH-1:0] pred_idx;
   logic [ADDR_WIDTH-1:0] upd_idx;
   logic [NUM_CTR-1:0]    ctr_msb;
   logic [NUM_CTR-1:0]    upd_en;
   logic                  pred_bit;

   assign pred_idx = in_pred_pc ^ ADDR_WIDTH'(ghr_q);
   assign upd_idx  = in_upd_pc  ^ ADDR_WIDTH'(in_upd_ghr);
   // Counters read their current state, so a same-cycle update is not visible here
   assign pred_bit = ctr_msb[pred_idx];

   always_comb begin
      upd_en = '0;
      if (in_upd_valid)
         upd_en[upd_idx] = 1'b1;
   end

   generate
      for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
         bpu_sat_ctr #(
            .CTR_WIDTH (CTR_WIDTH),
            .INIT      (CTR_INIT)
         ) u_ctr (
            .in_Clk  (in_Clk),
            .in_Rst  (in_Rst),
            .in_En   (upd_en[i]),
            .in_data (in_upd_taken),
            .out_msb (ctr_msb[i])
         );
      end
   endgenerate

   // Repair overrides the speculative shift; the shift form also covers GHR_WIDTH=1
   always_comb begin
      ghr_d        = ghr_q;
      pred_valid_d = in_pred_valid;
      prediction_d = prediction_q;
      pred_ghr_d   = pred_ghr_q;
      if (in_pred_valid) begin
         prediction_d = pred_bit;
         pred_ghr_d   = ghr_q;
         ghr_d        = (ghr_q << 1) | GHR_WIDTH'(pred_bit);
      end
      if (in_upd_valid && in_upd_mispredict)
         ghr_d = (in_upd_ghr << 1) | GHR_WIDTH'(in_upd_taken);
   end

   always_ff @(posedge in_Clk or posedge in_Rst) begin
      if (in_Rst) begin
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         prediction_q <= 1'b0;
         pred_ghr_q   <= '0;
      end else begin
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         prediction_q <= prediction_d;
         pred_ghr_q   <= pred_ghr_d;
      end
   end

   assign out_pred_valid = pred_valid_q;
   assign out_prediction = prediction_q;
   assign out_pred_ghr   = pred_ghr_q;
   assign out_ghr        = ghr_q;

endmodule
`default_nettype wire

// File: tb/tb_gshare_pht.sv
`default_nettype none
// ============================================================================
// tb_gshare_pht : directed table, reset corners and random traffic against a
//                 reference model of the gshare table.
// Revision: 1.0
// ============================================================================
module tb_gshare_pht;

   localparam int AW   = 9;
   localparam int GW   = 9;
   localparam int NCTR = 512;
   localparam int CMAX = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          pv;
   logic [AW-1:0] ppc;
   logic          o_pv;
   logic          o_pred;
   logic [GW-1:0] o_pghr;
   logic          uv;
   logic [AW-1:0] upc;
   logic [GW-1:0] ughr;
   logic          ut;
   logic          um;
   logic [GW-1:0] o_ghr;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_ctr [NCTR];
   int m_ghr;
   int m_pred;
   int m_pghr;

   gshare_pht dut (
      .in_Clk            (clk),
      .in_Rst            (rst),
      .in_pred_valid     (pv),
      .in_pred_pc        (ppc),
      .out_pred_valid    (o_pv),
      .out_prediction    (o_pred),
      .out_pred_ghr      (o_pghr),
      .in_upd_valid      (uv),
      .in_upd_pc         (upc),
      .in_upd_ghr        (ughr),
      .in_upd_taken      (ut),
      .in_upd_mispredict (um),
      .out_ghr           (o_ghr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          pv;
      logic [AW-1:0] ppc;
      logic          uv;
      logic [AW-1:0] upc;
      logic [GW-1:0] ughr;
      logic          ut;
      logic          um;
      logic          e_pv;
      logic          e_pred;
      logic [GW-1:0] e_pghr;
      logic [GW-1:0] e_ghr;
   } vec_t;

   vec_t tbl [23];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCTR; i++) m_ctr[i] = 1;
      m_ghr  = 0;
      m_pred = 0;
      m_pghr = 0;
   endtask

   // One clock of stimulus; the model is advanced from the rules and compared after the edge.
   task automatic step(input logic a_pv, input logic [AW-1:0] a_ppc, input logic a_uv,
                       input logic [AW-1:0] a_upc, input logic [GW-1:0] a_ughr,
                       input logic a_ut, input logic a_um);
      int pi, ui, p, e_pv;
      @(negedge clk);
      pv = a_pv; ppc = a_ppc; uv = a_uv; upc = a_upc; ughr = a_ughr; ut = a_ut; um = a_um;
      pi = int'(a_ppc) ^ m_ghr;
      p  = (m_ctr[pi] >= 2) ? 1 : 0;
      e_pv = a_pv ? 1 : 0;
      if (a_pv) begin
         m_pred = p;
         m_pghr = m_ghr;
      end
      if (a_uv) begin
         ui = int'(a_upc) ^ int'(a_ughr);
         if (a_ut && m_ctr[ui] < CMAX) m_ctr[ui] = m_ctr[ui] + 1;
         if (!a_ut && m_ctr[ui] > 0)   m_ctr[ui] = m_ctr[ui] - 1;
      end
      if (a_uv && a_um)
         m_ghr = (int'(a_ughr) * 2 + (a_ut ? 1 : 0)) % NCTR;
      else if (a_pv)
         m_ghr = (m_ghr * 2 + p) % NCTR;
      @(posedge clk);
      #1;
      chk("model_pred_valid", int'(o_pv), e_pv);
      chk("model_prediction", int'(o_pred), m_pred);
      chk("model_pred_ghr", int'(o_pghr), m_pghr);
      chk("model_ghr", int'(o_ghr), m_ghr);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pred_valid"}, int'(o_pv), 0);
      chk({tag, "_prediction"}, int'(o_pred), 0);
      chk({tag, "_pred_ghr"}, int'(o_pghr), 0);
      chk({tag, "_ghr"}, int'(o_ghr), 0);
   endtask

   initial begin
      //        pv ppc     uv upc     ughr    ut um  e_pv e_pred e_pghr  e_ghr
      tbl[0]  = '{1, 9'h010, 0, 9'h000, 9'h000, 0, 0, 1, 0, 9'h000, 9'h000};
      tbl[1]  = '{0, 9'h000, 1, 9'h010, 9'h000, 1, 0, 0, 0, 9'h000, 9'h000};
      tbl[2]  = '{0, 9'h000, 1, 9'h010, 9'h000, 1, 0, 0, 0, 9'h000, 9'h000};
      tbl[3]  = '{0, 9'h000, 1, 9'h010, 9'h000, 1, 0, 0, 0, 9'h000, 9'h000};
      tbl[4]  = '{0, 9'h000, 1, 9'h010, 9'h000, 0, 0, 0, 0, 9'h000, 9'h000};
      tbl[5]  = '{0, 9'h000, 1, 9'h010, 9'h000, 0, 0, 0, 0, 9'h000, 9'h000};
      tbl[6]  = '{0, 9'h000, 1, 9'h010, 9'h000, 0, 0, 0, 0, 9'h000, 9'h000};
      tbl[7]  = '{0, 9'h000, 1, 9'h010, 9'h000, 0, 0, 0, 0, 9'h000, 9'h000};
      tbl[8]  = '{0, 9'h000, 1, 9'h010, 9'h000, 1, 0, 0, 0, 9'h000, 9'h000};
      tbl[9]  = '{1, 9'h010, 0, 9'h000, 9'h000, 0, 0, 1, 0, 9'h000, 9'h000};
      tbl[10] = '{0, 9'h000, 1, 9'h000, 9'h052, 1, 1, 0, 0, 9'h000, 9'h0A5};
      tbl[11] = '{0, 9'h000, 1, 9'h0A5, 9'h0A5, 1, 0, 0, 0, 9'h000, 9'h0A5};
      tbl[12] = '{0, 9'h000, 1, 9'h0A5, 9'h0A5, 1, 0, 0, 0, 9'h000, 9'h0A5};
      tbl[13] = '{1, 9'h0A5, 0, 9'h000, 9'h000, 0, 0, 1, 1, 9'h0A5, 9'h14B};
      tbl[14] = '{0, 9'h000, 1, 9'h000, 9'h000, 0, 1, 0, 1, 9'h0A5, 9'h000};
      tbl[15] = '{1, 9'h020, 0, 9'h000, 9'h000, 0, 0, 1, 0, 9'h000, 9'h000};
      tbl[16] = '{1, 9'h020, 0, 9'h000, 9'h000, 0, 0, 1, 0, 9'h000, 9'h000};
      tbl[17] = '{1, 9'h020, 0, 9'h000, 9'h000, 0, 0, 1, 0, 9'h000, 9'h000};
      tbl[18] = '{0, 9'h000, 1, 9'h020, 9'h000, 1, 1, 0, 0, 9'h000, 9'h001};
      tbl[19] = '{1, 9'h031, 1, 9'h030, 9'h000, 1, 0, 1, 0, 9'h001, 9'h002};
      tbl[20] = '{1, 9'h032, 0, 9'h000, 9'h000, 0, 0, 1, 1, 9'h002, 9'h005};
      tbl[21] = '{1, 9'h000, 1, 9'h100, 9'h0F0, 1, 1, 1, 0, 9'h005, 9'h1E1};
      tbl[22] = '{0, 9'h000, 0, 9'h000, 9'h000, 0, 0, 0, 0, 9'h005, 9'h1E1};

      rst = 1'b1;
      pv = 0; ppc = '0; uv = 0; upc = '0; ughr = '0; ut = 0; um = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].pv, tbl[i].ppc, tbl[i].uv, tbl[i].upc, tbl[i].ughr, tbl[i].ut, tbl[i].um);
         chk($sformatf("vec%0d_pred_valid", i), int'(o_pv), int'(tbl[i].e_pv));
         chk($sformatf("vec%0d_prediction", i), int'(o_pred), int'(tbl[i].e_pred));
         chk($sformatf("vec%0d_pred_ghr", i), int'(o_pghr), int'(tbl[i].e_pghr));
         chk($sformatf("vec%0d_ghr", i), int'(o_ghr), int'(tbl[i].e_ghr));
      end

      // mispredict flag without a valid update must not touch the GHR
      step(0, 9'h000, 0, 9'h000, 9'h0FF, 1, 1);
      chk("stray_mispredict_ghr", int'(o_ghr), 9'h1E1);

      // asynchronous reset in the middle of a cycle with a request pending
      step(1, 9'h000, 0, 9'h000, 9'h000, 0, 0);
      #2;
      pv = 1'b1; ppc = 9'h0A5; uv = 1'b0; um = 1'b0;
      rst = 1'b1;
      #1;
      chk_zero("async_reset");
      pv = 1'b0; ppc = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
      @(negedge clk);
      rst = 1'b0;
      // idx 0x000 and 0x030 were trained to taken before the reset
      step(1, 9'h000, 0, 9'h000, 9'h000, 0, 0);
      chk("post_reset_ctr0", int'(o_pred), 0);
      step(1, 9'h030, 0, 9'h000, 9'h000, 0, 0);
      chk("post_reset_ctr30", int'(o_pred), 0);

      // random traffic concentrated on a small index window to exercise saturation
      for (int n = 0; n < 500; n++) begin
         logic [AW-1:0] r_ppc, r_upc;
         logic [GW-1:0] r_ughr;
         r_ppc  = AW'($urandom_range(0, 15));
         r_upc  = AW'($urandom_range(0, 15));
         r_ughr = GW'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), r_ppc, 1'($urandom_range(0, 1)), r_upc, r_ughr,
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
